// File: rtl/relogio_ajustavel_pkg.sv
// Shared types, moduli and hour-format helpers for the adjustable BCD clock.
package relogio_ajustavel_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } mode_t;

  typedef logic [3:0] bcd4_t;
  typedef logic [2:0] bcd3_t;
  typedef logic [1:0] bcd2_t;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  typedef struct packed {
    bcd2_t msd;
    bcd4_t lsd;
  } hour_bcd_t;

  function automatic logic is_pm(input bcd2_t msd, input bcd4_t lsd);
    return (msd == 2'd2) || ((msd == 2'd1) && (lsd >= 4'd2));
  endfunction

  // 00 -> 12, 13..23 -> 01..11, everything else unchanged
  function automatic hour_bcd_t to_12h(input bcd2_t msd, input bcd4_t lsd);
    logic [4:0] h;
    hour_bcd_t  r;
    h = 5'(msd) * 5'd10 + 5'(lsd);
    if (h == 5'd0) begin
      h = 5'd12;
    end else if (h > 5'd12) begin
      h = h - 5'd12;
    end else begin
      h = h;
    end
    if (h >= 5'd10) begin
      r.msd = 2'd1;
      r.lsd = 4'(h - 5'd10);
    end else begin
      r.msd = 2'd0;
      r.lsd = 4'(h);
    end
    return r;
  endfunction

endpackage

// File: rtl/relogio_ajustavel_if.sv
// Control inputs and display outputs of the clock, bundled with driver/DUT views.
interface relogio_ajustavel_if;
  import relogio_ajustavel_pkg::*;

  logic  btn_mode;
  logic  inc_min;
  logic  inc_hour;
  logic  mode_12h;
  logic  alarm_en;
  bcd4_t s_lsd;
  bcd3_t s_msd;
  bcd4_t m_lsd;
  bcd3_t m_msd;
  bcd4_t h_lsd;
  bcd2_t h_msd;
  logic  pm;
  mode_t mode;
  logic  alarm_out;

  modport master (
    output btn_mode, inc_min, inc_hour, mode_12h, alarm_en,
    input  s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd, pm, mode, alarm_out
  );

  modport slave (
    input  btn_mode, inc_min, inc_hour, mode_12h, alarm_en,
    output s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd, pm, mode, alarm_out
  );

endinterface

// File: rtl/relogio_ajustavel_bcd_mod_counter.sv
// Two-digit BCD modulo-MOD counter; exposes its next value so the parent can
// detect wraps and register the display in the same edge.
module bcd_mod_counter
  import relogio_ajustavel_pkg::*;
#(
  parameter int MOD   = 60,
  parameter int MSD_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output bcd4_t            nxt_lsd_o,
  output logic [MSD_W-1:0] nxt_msd_o
);
  localparam bcd4_t            TOP_LSD = 4'((MOD - 1) % 10);
  localparam logic [MSD_W-1:0] TOP_MSD = MSD_W'((MOD - 1) / 10);

  bcd4_t            lsd_q, lsd_d;
  logic [MSD_W-1:0] msd_q, msd_d;

  always_comb begin
    lsd_d = lsd_q;
    msd_d = msd_q;
    if (clr_i) begin
      lsd_d = 4'd0;
      msd_d = {MSD_W{1'b0}};
    end else if (inc_i) begin
      if ((lsd_q == TOP_LSD) && (msd_q == TOP_MSD)) begin
        lsd_d = 4'd0;
        msd_d = {MSD_W{1'b0}};
      end else if (lsd_q == 4'd9) begin
        lsd_d = 4'd0;
        msd_d = msd_q + MSD_W'(1);
      end else begin
        lsd_d = lsd_q + 4'd1;
      end
    end else begin
      lsd_d = lsd_q;
      msd_d = msd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsd_q <= 4'd0;
      msd_q <= {MSD_W{1'b0}};
    end else begin
      lsd_q <= lsd_d;
      msd_q <= msd_d;
    end
  end

  assign nxt_lsd_o = lsd_d;
  assign nxt_msd_o = msd_d;

endmodule

// File: rtl/relogio_ajustavel.sv
// Adjustable HH:MM:SS BCD clock: 1 Hz prescaler, RUN/SET_TIME/SET_ALARM modes,
// alarm timer and registered 24/12 h display.
module relogio_ajustavel
  import relogio_ajustavel_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int ALARM_SEC = 60
) (
  input logic                main_clock,
  input logic                main_reset,
  relogio_ajustavel_if.slave io
);
  localparam int              PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRE_MAX    = PW'(CLK_HZ - 1);
  localparam logic [7:0]      ALARM_LOAD = 8'(ALARM_SEC);

  mode_t         state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    al_cnt_q, al_cnt_d;
  logic          alarm_q, alarm_d;
  bcd4_t         s_lsd_q, s_lsd_d, m_lsd_q, m_lsd_d, h_lsd_q, h_lsd_d;
  bcd3_t         s_msd_q, s_msd_d, m_msd_q, m_msd_d;
  bcd2_t         h_msd_q, h_msd_d;
  logic          pm_q, pm_d;

  logic      run, tick, fire, edit_time, edit_alarm;
  logic      sec_clr, sec_wrap, min_inc, min_wrap, hour_inc;
  bcd4_t     sec_lsd, min_lsd, hour_lsd, al_min_lsd, al_hour_lsd;
  bcd3_t     sec_msd, min_msd, al_min_msd;
  bcd2_t     hour_msd, al_hour_msd;
  hour_bcd_t h24, h_disp;

  assign run        = (state_q == RUN);
  assign tick       = run && !io.btn_mode && (pre_q == PRE_MAX);
  assign edit_time  = (state_q == SET_TIME) && !io.btn_mode;
  assign edit_alarm = (state_q == SET_ALARM) && !io.btn_mode;

  // Seconds are zeroed on the way into SET_TIME and kept there while setting
  assign sec_clr  = (run && io.btn_mode) || (state_q == SET_TIME);
  assign sec_wrap = tick && (sec_lsd == 4'd0) && (sec_msd == 3'd0);
  assign min_inc  = sec_wrap || (edit_time && io.inc_min);
  assign min_wrap = sec_wrap && (min_lsd == 4'd0) && (min_msd == 3'd0);
  assign hour_inc = min_wrap || (edit_time && io.inc_hour);

  assign fire = tick && io.alarm_en && sec_wrap &&
                ({hour_msd, hour_lsd, min_msd, min_lsd} ==
                 {al_hour_msd, al_hour_lsd, al_min_msd, al_min_lsd});

  bcd_mod_counter #(.MOD(SEC_MOD), .MSD_W(3)) u_sec (
    .clk(main_clock), .rst(main_reset), .clr_i(sec_clr), .inc_i(tick),
    .nxt_lsd_o(sec_lsd), .nxt_msd_o(sec_msd)
  );
  bcd_mod_counter #(.MOD(MIN_MOD), .MSD_W(3)) u_min (
    .clk(main_clock), .rst(main_reset), .clr_i(1'b0), .inc_i(min_inc),
    .nxt_lsd_o(min_lsd), .nxt_msd_o(min_msd)
  );
  bcd_mod_counter #(.MOD(HOUR_MOD), .MSD_W(2)) u_hour (
    .clk(main_clock), .rst(main_reset), .clr_i(1'b0), .inc_i(hour_inc),
    .nxt_lsd_o(hour_lsd), .nxt_msd_o(hour_msd)
  );
  bcd_mod_counter #(.MOD(MIN_MOD), .MSD_W(3)) u_al_min (
    .clk(main_clock), .rst(main_reset), .clr_i(1'b0), .inc_i(edit_alarm && io.inc_min),
    .nxt_lsd_o(al_min_lsd), .nxt_msd_o(al_min_msd)
  );
  bcd_mod_counter #(.MOD(HOUR_MOD), .MSD_W(2)) u_al_hour (
    .clk(main_clock), .rst(main_reset), .clr_i(1'b0), .inc_i(edit_alarm && io.inc_hour),
    .nxt_lsd_o(al_hour_lsd), .nxt_msd_o(al_hour_msd)
  );

  always_comb begin
    state_d = state_q;
    if (io.btn_mode) begin
      case (state_q)
        RUN:      state_d = SET_TIME;
        SET_TIME: state_d = SET_ALARM;
        default:  state_d = RUN;
      endcase
    end else begin
      state_d = state_q;
    end

    if (run && !io.btn_mode) begin
      pre_d = (pre_q == PRE_MAX) ? {PW{1'b0}} : pre_q + PW'(1);
    end else begin
      pre_d = {PW{1'b0}};
    end

    // A fresh fire reloads the timer even while the alarm is already sounding
    al_cnt_d = al_cnt_q;
    alarm_d  = alarm_q;
    if (io.btn_mode || !io.alarm_en) begin
      al_cnt_d = 8'd0;
      alarm_d  = 1'b0;
    end else if (fire) begin
      al_cnt_d = ALARM_LOAD;
      alarm_d  = 1'b1;
    end else if (tick && alarm_q) begin
      al_cnt_d = (al_cnt_q <= 8'd1) ? 8'd0 : al_cnt_q - 8'd1;
      alarm_d  = (al_cnt_q > 8'd1);
    end else begin
      al_cnt_d = al_cnt_q;
      alarm_d  = alarm_q;
    end

    // Display is registered from next-state values, so it tracks the edge
    if (state_d == SET_ALARM) begin
      h24     = {al_hour_msd, al_hour_lsd};
      m_lsd_d = al_min_lsd;
      m_msd_d = al_min_msd;
      s_lsd_d = 4'd0;
      s_msd_d = 3'd0;
    end else begin
      h24     = {hour_msd, hour_lsd};
      m_lsd_d = min_lsd;
      m_msd_d = min_msd;
      s_lsd_d = sec_lsd;
      s_msd_d = sec_msd;
    end
    pm_d = is_pm(h24.msd, h24.lsd);
    if (io.mode_12h) begin
      h_disp = to_12h(h24.msd, h24.lsd);
    end else begin
      h_disp = h24;
    end
    h_lsd_d = h_disp.lsd;
    h_msd_d = h_disp.msd;
  end

  always_ff @(posedge main_clock) begin
    if (main_reset) begin
      state_q  <= RUN;
      pre_q    <= {PW{1'b0}};
      al_cnt_q <= 8'd0;
      alarm_q  <= 1'b0;
      s_lsd_q  <= 4'd0;
      s_msd_q  <= 3'd0;
      m_lsd_q  <= 4'd0;
      m_msd_q  <= 3'd0;
      h_lsd_q  <= 4'd0;
      h_msd_q  <= 2'd0;
      pm_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      al_cnt_q <= al_cnt_d;
      alarm_q  <= alarm_d;
      s_lsd_q  <= s_lsd_d;
      s_msd_q  <= s_msd_d;
      m_lsd_q  <= m_lsd_d;
      m_msd_q  <= m_msd_d;
      h_lsd_q  <= h_lsd_d;
      h_msd_q  <= h_msd_d;
      pm_q     <= pm_d;
    end
  end

  assign io.mode      = state_q;
  assign io.alarm_out = alarm_q;
  assign io.s_lsd     = s_lsd_q;
  assign io.s_msd     = s_msd_q;
  assign io.m_lsd     = m_lsd_q;
  assign io.m_msd     = m_msd_q;
  assign io.h_lsd     = h_lsd_q;
  assign io.h_msd     = h_msd_q;
  assign io.pm        = pm_q;

endmodule

// File: tb/tb_relogio_ajustavel.sv
// Bench for relogio_ajustavel: directed scenarios plus random stimulus, all
// checked against a seconds-of-day reference model.
module tb_relogio_ajustavel;
  import relogio_ajustavel_pkg::*;

  localparam int CLK_HZ    = 4;
  localparam int ALARM_SEC = 3;

  logic main_clock = 1'b0;
  logic main_reset = 1'b1;

  relogio_ajustavel_if bus ();

  relogio_ajustavel #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .main_clock(main_clock),
    .main_reset(main_reset),
    .io        (bus.slave)
  );

  always #5 main_clock = ~main_clock;

  int total = 0;
  int bad   = 0;

  // reference model state: time as seconds of day, alarm as minute of day
  int m_t, m_al, m_mode, m_pre, m_rem;
  bit m_out;
  bit cur_m12;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit btn, input bit im, input bit ih, input bit en);
    bit tick, fire;
    int h, m;
    if (rst) begin
      m_t = 0; m_al = 0; m_mode = 0; m_pre = 0; m_rem = 0; m_out = 0;
    end else begin
      tick = (m_mode == 0) && !btn && (m_pre == CLK_HZ - 1);
      fire = 0;
      if ((m_mode == 0) && !btn) m_pre = (m_pre + 1) % CLK_HZ;
      else m_pre = 0;
      if (tick) begin
        m_t  = (m_t + 1) % 86400;
        fire = en && (m_t % 60 == 0) && (m_t / 60 == m_al);
      end
      if (btn) begin
        if (m_mode == 0) m_t = m_t - (m_t % 60);
        m_mode = (m_mode + 1) % 3;
      end else if (m_mode == 1) begin
        h = m_t / 3600; m = (m_t / 60) % 60;
        if (im) m = (m + 1) % 60;
        if (ih) h = (h + 1) % 24;
        m_t = h * 3600 + m * 60;
      end else if (m_mode == 2) begin
        h = m_al / 60; m = m_al % 60;
        if (im) m = (m + 1) % 60;
        if (ih) h = (h + 1) % 24;
        m_al = h * 60 + m;
      end
      if (btn || !en) begin
        m_out = 0; m_rem = 0;
      end else if (fire) begin
        m_out = 1; m_rem = ALARM_SEC;
      end else if (tick && m_out) begin
        m_rem--;
        if (m_rem == 0) m_out = 0;
      end
    end
  endtask

  task automatic compare_model();
    int h, mn, s, hd;
    h  = (m_mode == 2) ? m_al / 60 : m_t / 3600;
    mn = (m_mode == 2) ? m_al % 60 : (m_t / 60) % 60;
    s  = (m_mode == 2) ? 0 : m_t % 60;
    hd = h;
    if (cur_m12) hd = (h % 12 == 0) ? 12 : h % 12;
    check("s_lsd", int'(bus.s_lsd), s % 10);
    check("s_msd", int'(bus.s_msd), s / 10);
    check("m_lsd", int'(bus.m_lsd), mn % 10);
    check("m_msd", int'(bus.m_msd), mn / 10);
    check("h_lsd", int'(bus.h_lsd), hd % 10);
    check("h_msd", int'(bus.h_msd), hd / 10);
    check("pm", int'(bus.pm), int'(h >= 12));
    check("mode", int'(bus.mode), m_mode);
    check("alarm_out", int'(bus.alarm_out), int'(m_out));
    check("bcd_legal", int'(bus.s_lsd <= 4'd9 && bus.s_msd <= 3'd5 && bus.m_lsd <= 4'd9 &&
                            bus.m_msd <= 3'd5 && bus.h_lsd <= 4'd9 && bus.h_msd <= 2'd2), 1);
  endtask

  task automatic cyc(input bit rst, input bit btn, input bit im, input bit ih,
                     input bit en, input bit m12);
    main_reset   = rst;
    bus.btn_mode = btn;
    bus.inc_min  = im;
    bus.inc_hour = ih;
    bus.alarm_en = en;
    bus.mode_12h = m12;
    cur_m12      = m12;
    @(posedge main_clock);
    model_step(rst, btn, im, ih, en);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, en, 1'b0);
  endtask

  // alarm 00:01, time 00:00:00, RUN restarted; stops just before the fire edge
  task automatic alarm_setup(input bit en);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, en, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, en, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, en, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, en, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, en, 1'b0);
    idle(239, en);
    check("alarm_before_match", int'(bus.alarm_out), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, en, 1'b0);
    check("alarm_match_min", int'(bus.m_lsd), 1);
    check("alarm_rise", int'(bus.alarm_out), int'(en));
  endtask

  initial begin
    bus.btn_mode = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
    bus.alarm_en = 1'b0; bus.mode_12h = 1'b0; cur_m12 = 1'b0;

    // 1: reset and free running
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_s_lsd", int'(bus.s_lsd), 0);
    check("rst_mode", int'(bus.mode), 0);
    idle(4, 1'b0);
    check("t1_first_tick", int'(bus.s_lsd), 1);
    idle(236, 1'b0);
    check("t1_one_min_m", int'(bus.m_lsd), 1);
    check("t1_one_min_s", int'(bus.s_msd) * 10 + int'(bus.s_lsd), 0);

    // 2: 23:59:00 preload, roll over midnight
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) cyc(1'b0, 1'b0, 1'b1, (i < 23), 1'b0, 1'b0);
    check("t2_preload_h", int'(bus.h_msd) * 10 + int'(bus.h_lsd), 23);
    check("t2_preload_m", int'(bus.m_msd) * 10 + int'(bus.m_lsd), 59);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(236, 1'b0);
    check("t2_235959_s", int'(bus.s_msd) * 10 + int'(bus.s_lsd), 59);
    idle(4, 1'b0);
    check("t2_midnight_h", int'(bus.h_msd) * 10 + int'(bus.h_lsd), 0);
    check("t2_midnight_m", int'(bus.m_msd) * 10 + int'(bus.m_lsd), 0);
    check("t2_midnight_pm", int'(bus.pm), 0);

    // 3: 14:03 hold, then 12 h display
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20, 1'b0);
    check("t3_hold_h", int'(bus.h_msd) * 10 + int'(bus.h_lsd), 14);
    check("t3_hold_m", int'(bus.m_msd) * 10 + int'(bus.m_lsd), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_12h_h", int'(bus.h_msd) * 10 + int'(bus.h_lsd), 2);
    check("t3_12h_pm", int'(bus.pm), 1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_12h_mid_h", int'(bus.h_msd) * 10 + int'(bus.h_lsd), 12);
    check("t3_12h_mid_pm", int'(bus.pm), 0);

    // 4: alarm pulse, then disabled alarm
    alarm_setup(1'b1);
    idle(11, 1'b1);
    check("t4_alarm_held", int'(bus.alarm_out), 1);
    idle(1, 1'b1);
    check("t4_alarm_clear", int'(bus.alarm_out), 0);
    alarm_setup(1'b0);
    idle(12, 1'b0);
    check("t4_no_alarm", int'(bus.alarm_out), 0);

    // 5: btn_mode beats inc_min; inc_* ignored in RUN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_mode_adv", int'(bus.mode), 1);
    check("t5_min_kept", int'(bus.m_lsd), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_run_inc_m", int'(bus.m_lsd), 0);
    check("t5_run_inc_h", int'(bus.h_lsd), 0);

    // 6: reset with alarm high, and reset while editing the alarm
    alarm_setup(1'b1);
    idle(2, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_rst_alarm", int'(bus.alarm_out), 0);
    check("t6_rst_m", int'(bus.m_lsd), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_set_alarm_h", int'(bus.h_lsd), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_rst_mode", int'(bus.mode), 0);
    check("t6_rst_h", int'(bus.h_lsd), 0);

    // random phase
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_btn, r_im, r_ih, r_en, r_m12;
      r_rst = ($urandom_range(0, 699) == 0);
      r_btn = ($urandom_range(0, 29) == 0);
      r_im  = ($urandom_range(0, 2) == 0);
      r_ih  = ($urandom_range(0, 2) == 0);
      r_en  = ($urandom_range(0, 15) != 0);
      r_m12 = ($urandom_range(0, 19) == 0) ? ~cur_m12 : cur_m12;
      cyc(r_rst, r_btn, r_im, r_ih, r_en, r_m12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
